// File: rtl/risc_y_pkg.sv
// ----------------------------------------------------------------------------
// risc_y_pkg
// Shared definitions for the tiny accumulator processor's control path.
// Contents:
//   state_e    - control FSM states (IDLE, FETCH, DECODE, EXECUTE, HALT)
//   opcode_e   - 3-bit opcode carried in IR[7:5]
//   alu_op_e   - 2-bit ALU function select seen on ALU_OP
//   get_opcode - extracts the opcode field from an instruction word
//   get_operand- extracts the 5-bit operand / jump target from IR[4:0]
// ----------------------------------------------------------------------------
package risc_y_pkg;

   localparam int IR_W      = 8;
   localparam int OPERAND_W = 5;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_DECODE  = 3'd2,
      ST_EXECUTE = 3'd3,
      ST_HALT    = 3'd4
   } state_e;

   typedef enum logic [2:0] {
      OP_NOP   = 3'b000,
      OP_LOAD  = 3'b001,
      OP_STORE = 3'b010,
      OP_ADD   = 3'b011,
      OP_SUB   = 3'b100,
      OP_JMP   = 3'b101,
      OP_JZ    = 3'b110,
      OP_HLT   = 3'b111
   } opcode_e;

   typedef enum logic [1:0] {
      ALU_PASS = 2'b00,
      ALU_ADD  = 2'b01,
      ALU_SUB  = 2'b10,
      ALU_RSVD = 2'b11
   } alu_op_e;

   function automatic opcode_e get_opcode(input logic [IR_W-1:0] instr);
      return opcode_e'(instr[IR_W-1:OPERAND_W]);
   endfunction

   function automatic logic [OPERAND_W-1:0] get_operand(input logic [IR_W-1:0] instr);
      return instr[OPERAND_W-1:0];
   endfunction

endpackage

// File: rtl/ir_reg.sv
// ----------------------------------------------------------------------------
// ir_reg
// Instruction register: captures the instruction word when load is high and
// otherwise holds it. clr is synchronous and wins over load, so a reset that
// lands on a capture edge still leaves the register at zero.
// Ports:
//   clk  - rising-edge clock
//   clr  - synchronous clear, active high
//   load - capture enable
//   d    - instruction word to capture
//   q    - registered instruction word
// ----------------------------------------------------------------------------
module ir_reg
   import risc_y_pkg::*;
(
   input  logic            clk,
   input  logic            clr,
   input  logic            load,
   input  logic [IR_W-1:0] d,
   output logic [IR_W-1:0] q
);

   logic [IR_W-1:0] ir_d;
   logic [IR_W-1:0] ir_q;

   // Next value: take the new word only on a load, otherwise hold.
   always_comb begin
      ir_d = ir_q;
      if (load) begin
         ir_d = d;
      end
   end

   // Register with synchronous clear taking priority over the load.
   always_ff @(posedge clk) begin
      if (clr) begin
         ir_q <= '0;
      end else begin
         ir_q <= ir_d;
      end
   end

   assign q = ir_q;

endmodule

// File: rtl/fetch_ctrl.sv
// ----------------------------------------------------------------------------
// fetch_ctrl
// Control unit for the accumulator processor. Sequences every instruction
// through FETCH, DECODE and EXECUTE, captures the instruction word in ir_reg
// and decodes it into datapath strobes during EXECUTE.
// Ports:
//   CLK      - rising-edge clock
//   RST      - synchronous reset, active high
//   RUN      - start request, only looked at in IDLE
//   INSTR    - instruction word from instruction memory, used in FETCH
//   ZERO     - ALU zero flag, decides the conditional jump in EXECUTE
//   PC_EN    - program counter advance/load enable (one pulse per instr)
//   LOAD_EN  - program counter load select (jump taken)
//   JMP_ADDR - jump target, always the low 5 bits of the IR
//   IR_EN    - instruction capture in progress (FETCH)
//   ALU_OP   - 00 pass, 01 add, 10 sub
//   REG_WE   - accumulator write enable
//   MEM_WE   - data memory write enable
//   HALTED   - processor stopped, only reset leaves this state
// ----------------------------------------------------------------------------
module fetch_ctrl
   import risc_y_pkg::*;
(
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 RUN,
   input  logic [IR_W-1:0]      INSTR,
   input  logic                 ZERO,
   output logic                 PC_EN,
   output logic                 LOAD_EN,
   output logic [OPERAND_W-1:0] JMP_ADDR,
   output logic                 IR_EN,
   output logic [1:0]           ALU_OP,
   output logic                 REG_WE,
   output logic                 MEM_WE,
   output logic                 HALTED
);

   state_e          state_d;
   state_e          state_q;
   logic [IR_W-1:0] ir;
   opcode_e         opcode;
   logic            exec_active;

   ir_reg u_ir (
      .clk  (CLK),
      .clr  (RST),
      .load (state_q == ST_FETCH),
      .d    (INSTR),
      .q    (ir)
   );

   assign opcode   = get_opcode(ir);
   assign JMP_ADDR = get_operand(ir);

   // Strobes are suppressed while RST is high so that a reset landing on an
   // EXECUTE cycle can never advance the PC or write the accumulator/memory.
   assign exec_active = (state_q == ST_EXECUTE) && !RST;

   // State register; reset overrides every transition including HALT.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. HALT is absorbing; RUN matters only in IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    state_d = RUN ? ST_FETCH : ST_IDLE;
         ST_FETCH:   state_d = ST_DECODE;
         ST_DECODE:  state_d = ST_EXECUTE;
         ST_EXECUTE: state_d = (opcode == OP_HLT) ? ST_HALT : ST_FETCH;
         ST_HALT:    state_d = ST_HALT;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Output decode. Everything defaults to idle values; only EXECUTE drives
   // datapath strobes, and every opcode except HLT advances the PC once.
   always_comb begin
      PC_EN   = 1'b0;
      LOAD_EN = 1'b0;
      REG_WE  = 1'b0;
      MEM_WE  = 1'b0;
      ALU_OP  = ALU_PASS;
      IR_EN   = (state_q == ST_FETCH);
      HALTED  = (state_q == ST_HALT);
      if (exec_active) begin
         PC_EN = (opcode != OP_HLT);
         unique case (opcode)
            OP_LOAD: begin
               REG_WE = 1'b1;
               ALU_OP = ALU_PASS;
            end
            OP_STORE: MEM_WE = 1'b1;
            OP_ADD: begin
               REG_WE = 1'b1;
               ALU_OP = ALU_ADD;
            end
            OP_SUB: begin
               REG_WE = 1'b1;
               ALU_OP = ALU_SUB;
            end
            OP_JMP:  LOAD_EN = 1'b1;
            OP_JZ:   LOAD_EN = ZERO;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fetch_ctrl
// Self-checking bench for fetch_ctrl. A behavioural model tracks whether the
// processor is idle, running or halted, which of the three instruction cycles
// it is in, and the captured instruction; expected outputs are derived from
// the opcode rules each cycle. Directed scenarios come first, then random
// traffic with occasional resets.
// ----------------------------------------------------------------------------
module tb_fetch_ctrl;

   logic       CLK;
   logic       RST;
   logic       RUN;
   logic [7:0] INSTR;
   logic       ZERO;
   logic       PC_EN;
   logic       LOAD_EN;
   logic [4:0] JMP_ADDR;
   logic       IR_EN;
   logic [1:0] ALU_OP;
   logic       REG_WE;
   logic       MEM_WE;
   logic       HALTED;

   int checksTotal;
   int checksPassed;

   // Reference model: mode 0 idle, 1 running, 2 halted;
   // step is the cycle index within the current instruction (0..2).
   int         modelMode;
   int         modelStep;
   logic [7:0] modelIr;

   fetch_ctrl dut (
      .CLK      (CLK),
      .RST      (RST),
      .RUN      (RUN),
      .INSTR    (INSTR),
      .ZERO     (ZERO),
      .PC_EN    (PC_EN),
      .LOAD_EN  (LOAD_EN),
      .JMP_ADDR (JMP_ADDR),
      .IR_EN    (IR_EN),
      .ALU_OP   (ALU_OP),
      .REG_WE   (REG_WE),
      .MEM_WE   (MEM_WE),
      .HALTED   (HALTED)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checksTotal++;
      if (observed === expected) begin
         checksPassed++;
      end else begin
         $display("[TB] FAIL %s: observed %0h, expected %0h at time %0t", tag, observed, expected, $time);
      end
   endtask

   // Drives one cycle of inputs, checks outputs mid-cycle against the model,
   // then advances the model across the rising edge.
   task automatic applyStimulus(input logic run, input logic [7:0] instr, input logic zero, input logic rst);
      int         op;
      logic       execNow;
      logic       expPc;
      logic       expLoad;
      logic       expReg;
      logic       expMem;
      logic [1:0] expAlu;
      RUN   = run;
      INSTR = instr;
      ZERO  = zero;
      RST   = rst;
      #4;
      op      = int'(modelIr[7:5]);
      execNow = (modelMode == 1) && (modelStep == 2) && !rst;
      expPc   = execNow && (op != 7);
      expLoad = execNow && ((op == 5) || (op == 6 && zero));
      expReg  = execNow && (op == 1 || op == 3 || op == 4);
      expMem  = execNow && (op == 2);
      expAlu  = 2'b00;
      if (expReg && op == 3) expAlu = 2'b01;
      if (expReg && op == 4) expAlu = 2'b10;
      checkOutput("PC_EN",    {7'd0, PC_EN},    {7'd0, expPc});
      checkOutput("LOAD_EN",  {7'd0, LOAD_EN},  {7'd0, expLoad});
      checkOutput("JMP_ADDR", {3'd0, JMP_ADDR}, {3'd0, modelIr[4:0]});
      checkOutput("IR_EN",    {7'd0, IR_EN},    {7'd0, (modelMode == 1) && (modelStep == 0)});
      checkOutput("ALU_OP",   {6'd0, ALU_OP},   {6'd0, expAlu});
      checkOutput("REG_WE",   {7'd0, REG_WE},   {7'd0, expReg});
      checkOutput("MEM_WE",   {7'd0, MEM_WE},   {7'd0, expMem});
      checkOutput("HALTED",   {7'd0, HALTED},   {7'd0, modelMode == 2});
      @(posedge CLK);
      if (rst) begin
         modelMode = 0;
         modelStep = 0;
         modelIr   = 8'h00;
      end else if (modelMode == 0) begin
         if (run) begin
            modelMode = 1;
            modelStep = 0;
         end
      end else if (modelMode == 1) begin
         if (modelStep == 0) begin
            modelIr   = instr;
            modelStep = 1;
         end else if (modelStep == 1) begin
            modelStep = 2;
         end else if (op == 7) begin
            modelMode = 2;
         end else begin
            modelStep = 0;
         end
      end
      #1;
   endtask

   // Reset, one RUN pulse, then the given instruction word for n cycles.
   task automatic runInstr(input logic [7:0] instr, input logic zero, input int n);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, instr, zero, 1'b0);
   endtask

   initial begin
      checksTotal  = 0;
      checksPassed = 0;
      modelMode    = 0;
      modelStep    = 0;
      modelIr      = 8'h00;
      RST   = 1'b1;
      RUN   = 1'b0;
      INSTR = 8'h00;
      ZERO  = 1'b0;
      @(posedge CLK);
      #1;

      // Reset state, then ADD 1 through one full instruction and into the next.
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      runInstr(8'h61, 1'b0, 5);

      // JMP 20.
      runInstr(8'hB4, 1'b0, 3);

      // JZ 9 with ZERO low then high, back to back.
      runInstr(8'hC9, 1'b0, 3);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'hC9, 1'b1, 1'b0);

      // STORE 10, plus LOAD and SUB for the remaining ALU selects.
      runInstr(8'h4A, 1'b1, 4);
      runInstr(8'h23, 1'b0, 3);
      runInstr(8'h85, 1'b0, 3);

      // HLT: stays halted with RUN high, then reset and an idle cycle.
      runInstr(8'hE0, 1'b0, 3);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h61, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'h61, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

      // Reset landing on the EXECUTE cycle of an ADD.
      runInstr(8'h61, 1'b0, 2);
      applyStimulus(1'b0, 8'h61, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h61, 1'b0, 1'b0);

      // Random traffic; HLT made rarer so long programs still get exercised.
      for (int i = 0; i < 2000; i++) begin
         logic [7:0] instr;
         instr = 8'($urandom);
         if (instr[7:5] == 3'b111 && $urandom_range(3, 0) != 0) instr[7:5] = 3'b011;
         applyStimulus(1'($urandom_range(1, 0)), instr, 1'($urandom_range(1, 0)),
                       $urandom_range(49, 0) == 0);
      end

      $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
